// File: rtl/lc3_mem_responder_pkg.sv
// Shared definitions for the LC-3 memory responder: device offsets, FSM states,
// MCR reset value and the device address decoder.
package lc3_mem_responder_pkg;

  localparam logic [15:0] KBSR_OFS  = 16'h0000;
  localparam logic [15:0] KBDR_OFS  = 16'h0002;
  localparam logic [15:0] DSR_OFS   = 16'h0004;
  localparam logic [15:0] DDR_OFS   = 16'h0006;
  localparam logic [15:0] MCR_RESET = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMWAIT,
    ST_RESP
  } state_t;

  typedef enum logic [2:0] {
    DEV_KBSR,
    DEV_KBDR,
    DEV_DSR,
    DEV_DDR,
    DEV_MCR,
    DEV_NONE
  } dev_t;

  // Exact-match decode; anything else in device space reads as zero.
  function automatic dev_t dev_decode(input logic [15:0] addr,
                                      input logic [15:0] kb_base,
                                      input logic [15:0] mcr_addr);
    if (addr == mcr_addr)            return DEV_MCR;
    if (addr == kb_base + KBSR_OFS)  return DEV_KBSR;
    if (addr == kb_base + KBDR_OFS)  return DEV_KBDR;
    if (addr == kb_base + DSR_OFS)   return DEV_DSR;
    if (addr == kb_base + DDR_OFS)   return DEV_DDR;
    return DEV_NONE;
  endfunction

endpackage

// File: rtl/lc3_kbd_port.sv
// Keyboard data register: captures one character at a time and holds it until
// the datapath reads KBDR.
module lc3_kbd_port (
  input  logic       clk,
  input  logic       reset,
  input  logic       kb_valid,
  input  logic [7:0] kb_data,
  input  logic       clr,
  output logic       kb_full,
  output logic [7:0] kbdr,
  output logic       kb_ack
);

  // A KBDR read clearing the register takes priority over a new character;
  // the pending character is then captured on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      kb_full <= 1'b0;
      kbdr    <= 8'h00;
      kb_ack  <= 1'b0;
    end else begin
      kb_ack <= 1'b0;
      if (clr) begin
        kb_full <= 1'b0;
      end else if (kb_valid && !kb_full) begin
        kbdr    <= kb_data;
        kb_full <= 1'b1;
        kb_ack  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for LC-3 MAR/MDR requests: routes each request to RAM
// (with wait-states) or to the memory-mapped keyboard/display/MCR registers.
module lc3_mem_responder
  import lc3_mem_responder_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] KB_ADDR     = 16'hFE00,
  parameter logic [15:0] MCR_ADDR    = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  output logic        ram_en,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ack,
  output logic        dd_valid,
  output logic [7:0]  dd_data,
  input  logic        dd_ready,
  output logic        mcr_run
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              mcr_bit;
  logic              stale;
  logic              kbdr_clr;
  logic              kb_full;
  logic [7:0]        kbdr;
  dev_t              dev;
  logic [15:0]       dev_rdata;

  assign dev     = dev_decode(mem_addr, KB_ADDR, MCR_ADDR);
  assign mcr_run = mcr_bit;

  always_comb begin
    dev_rdata = 16'h0000;
    case (dev)
      DEV_KBSR: dev_rdata = {kb_full, 15'b0};
      DEV_KBDR: dev_rdata = {8'b0, kbdr};
      DEV_DSR:  dev_rdata = {~dd_valid, 15'b0};
      DEV_MCR:  dev_rdata = {mcr_bit, 15'b0};
      default:  dev_rdata = 16'h0000;
    endcase
  end

  lc3_kbd_port u_kbd (
    .clk      (clk),
    .reset    (reset),
    .kb_valid (kb_valid),
    .kb_data  (kb_data),
    .clr      (kbdr_clr),
    .kb_full  (kb_full),
    .kbdr     (kbdr),
    .kb_ack   (kb_ack)
  );

  // stale blocks a request that is still held from the transaction that just
  // completed, so one request can never be serviced twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= 16'h0000;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      dd_valid  <= 1'b0;
      dd_data   <= 8'h00;
      mcr_bit   <= MCR_RESET[15];
      stale     <= 1'b0;
      kbdr_clr  <= 1'b0;
    end else begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      mem_ready <= 1'b0;
      kbdr_clr  <= 1'b0;
      if (dd_valid && dd_ready) dd_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          stale <= 1'b0;
          if (mem_en && !stale) begin
            if (mem_addr >= KB_ADDR) begin
              state     <= ST_RESP;
              mem_ready <= 1'b1;
              mem_rdata <= mem_we ? 16'h0000 : dev_rdata;
              kbdr_clr  <= !mem_we && (dev == DEV_KBDR);
              if (mem_we) begin
                case (dev)
                  DEV_DDR: begin
                    if (!dd_valid) begin
                      dd_valid <= 1'b1;
                      dd_data  <= mem_wdata[7:0];
                    end
                  end
                  DEV_MCR: mcr_bit <= mem_wdata[15];
                  default: ;
                endcase
              end
            end else begin
              ram_en    <= 1'b1;
              ram_we    <= mem_we;
              ram_addr  <= mem_addr;
              ram_wdata <= mem_wdata;
              if (mem_we) begin
                state     <= ST_RESP;
                mem_ready <= 1'b1;
              end else begin
                state    <= ST_RAMWAIT;
                wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
              end
            end
          end
        end

        ST_RAMWAIT: begin
          if (wait_cnt == '0) begin
            mem_rdata <= ram_rdata;
            mem_ready <= 1'b1;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        ST_RESP: begin
          stale <= mem_en;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder: directed scenarios followed by
// randomized traffic checked against a register/memory-level reference model.
module tb_lc3_mem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_en = 1'b0;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr = 16'h0000;
  logic [15:0] mem_wdata = 16'h0000;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        kb_valid = 1'b0;
  logic [7:0]  kb_data = 8'h00;
  logic        kb_ack;
  logic        dd_valid;
  logic [7:0]  dd_data;
  logic        dd_ready = 1'b0;
  logic        mcr_run;

  always #5 clk = ~clk;

  lc3_mem_responder #(.WAIT_CYCLES(W), .KB_ADDR(16'hFE00), .MCR_ADDR(16'hFFFE)) dut (
    .clk(clk), .reset(reset), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .kb_valid(kb_valid), .kb_data(kb_data), .kb_ack(kb_ack),
    .dd_valid(dd_valid), .dd_data(dd_data), .dd_ready(dd_ready),
    .mcr_run(mcr_run)
  );

  // RAM stub: synchronous read, data held until the next read.
  logic [15:0] ram [0:255];
  logic [15:0] rdata_q;
  assign ram_rdata = rdata_q;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr[7:0]] <= ram_wdata;
      else        rdata_q <= ram[ram_addr[7:0]];
    end
  end

  // Reference model state
  logic [15:0] ref_mem [0:255];
  bit          ref_full;
  logic [7:0]  ref_kbdr;
  bit          ref_ddv;
  logic [7:0]  ref_ddd;
  bit          ref_mcr;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dev_read(input logic [15:0] a);
    case (a)
      16'hFE00: return {ref_full, 15'b0};
      16'hFE02: return {8'h00, ref_kbdr};
      16'hFE04: return {~ref_ddv, 15'b0};
      16'hFFFE: return {ref_mcr, 15'b0};
      default:  return 16'h0000;
    endcase
  endfunction

  task automatic dev_write(input logic [15:0] a, input logic [15:0] d);
    if (a == 16'hFE06 && !ref_ddv) begin
      ref_ddv = 1'b1;
      ref_ddd = d[7:0];
    end
    if (a == 16'hFFFE) ref_mcr = d[15];
  endtask

  task automatic model_reset();
    ref_full = 1'b0;
    ref_kbdr = 8'h00;
    ref_ddv  = 1'b0;
    ref_ddd  = 8'h00;
    ref_mcr  = 1'b1;
  endtask

  // Issue one request and observe it cycle by cycle until ready (bounded).
  task automatic do_req(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                        input bit drop_early, output logic [15:0] rd, output int lat,
                        output int pulses, output bit swe, output logic [15:0] saddr,
                        output logic [15:0] swd);
    bit got;
    got = 1'b0; lat = 0; pulses = 0; swe = 1'b0; saddr = 16'h0; swd = 16'h0; rd = 16'h0;
    @(negedge clk);
    mem_en = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (drop_early) mem_en = 1'b0;
      if (ram_en) begin
        pulses++;
        swe = ram_we; saddr = ram_addr; swd = ram_wdata;
      end
      if (mem_ready) begin
        got = 1'b1; lat = i; rd = mem_rdata;
        mem_en = 1'b0;
      end
    end
    mem_en = 1'b0;
    @(negedge clk);
    chk("ready_one_cycle", mem_ready, 1'b0);
  endtask

  task automatic op(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                    input bit drop_early, input string tag);
    logic [15:0] rd, saddr, swd, exp_rd;
    int lat, pulses;
    bit swe, dev;
    dev    = (addr >= 16'hFE00);
    exp_rd = dev ? dev_read(addr) : ref_mem[addr[7:0]];
    do_req(we, addr, wdata, drop_early, rd, lat, pulses, swe, saddr, swd);
    chk({tag, "_lat"}, lat, (dev || we) ? 1 : 1 + W);
    chk({tag, "_ram_en_cnt"}, pulses, dev ? 0 : 1);
    if (!dev) begin
      chk({tag, "_ram_addr"}, saddr, addr);
      chk({tag, "_ram_we"}, swe, we);
      if (we) chk({tag, "_ram_wdata"}, swd, wdata);
    end
    if (!we) chk({tag, "_rdata"}, rd, exp_rd);
    if (!dev && we) ref_mem[addr[7:0]] = wdata;
    if (dev && we) dev_write(addr, wdata);
    if (dev && !we && addr == 16'hFE02) ref_full = 1'b0;
    chk({tag, "_dd_valid"}, dd_valid, ref_ddv);
    if (ref_ddv) chk({tag, "_dd_data"}, dd_data, ref_ddd);
    chk({tag, "_mcr_run"}, mcr_run, ref_mcr);
  endtask

  task automatic kb_send(input logic [7:0] ch);
    @(negedge clk);
    kb_valid = 1'b1; kb_data = ch;
    @(negedge clk);
    chk("kb_ack_pulse", kb_ack, 1'b1);
    kb_valid = 1'b0;
    ref_full = 1'b1; ref_kbdr = ch;
    @(negedge clk);
    chk("kb_ack_single", kb_ack, 1'b0);
  endtask

  task automatic dd_release();
    @(negedge clk);
    dd_ready = 1'b1;
    @(negedge clk);
    dd_ready = 1'b0;
    ref_ddv = 1'b0;
    chk("dd_released", dd_valid, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [15:0] v, a, d;
    logic [15:0] dev_list [0:6];
    int sel, lat, pulses, rdy_seen;
    logic [15:0] rd, saddr, swd;
    bit swe;

    dev_list[0] = 16'hFE00; dev_list[1] = 16'hFE02; dev_list[2] = 16'hFE04;
    dev_list[3] = 16'hFE06; dev_list[4] = 16'hFFFE; dev_list[5] = 16'hFE10;
    dev_list[6] = 16'hFFFF;

    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      ram[i] <= v;
      ref_mem[i] = v;
    end
    ram[0] <= 16'h1234;
    ref_mem[0] = 16'h1234;
    model_reset();

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_mem_ready", mem_ready, 1'b0);
    chk("rst_mem_rdata", mem_rdata, 16'h0000);
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_kb_ack", kb_ack, 1'b0);
    chk("rst_dd_valid", dd_valid, 1'b0);
    chk("rst_dd_data", dd_data, 8'h00);
    chk("rst_mcr_run", mcr_run, 1'b1);

    // RAM read, write, read-back
    op(1'b0, 16'h3000, 16'h0000, 1'b0, "ram_rd_1234");
    op(1'b1, 16'h3001, 16'hBEEF, 1'b0, "ram_wr_beef");
    op(1'b0, 16'h3001, 16'h0000, 1'b1, "ram_rb_beef");

    // Keyboard: capture, status, data, status cleared
    kb_send(8'h41);
    op(1'b0, 16'hFE00, 16'h0, 1'b0, "kbsr_full");
    op(1'b0, 16'hFE02, 16'h0, 1'b0, "kbdr_41");
    op(1'b0, 16'hFE00, 16'h0, 1'b0, "kbsr_empty");

    // Clear beats a simultaneous new character; capture follows a cycle later
    kb_send(8'h41);
    @(negedge clk);
    kb_valid = 1'b1; kb_data = 8'h42;
    @(negedge clk);
    chk("kb_no_ack_when_full", kb_ack, 1'b0);
    op(1'b0, 16'hFE02, 16'h0, 1'b0, "kbdr_old");
    @(negedge clk);
    chk("kb_ack_after_clear", kb_ack, 1'b1);
    kb_valid = 1'b0;
    ref_full = 1'b1; ref_kbdr = 8'h42;
    op(1'b0, 16'hFE02, 16'h0, 1'b0, "kbdr_42");

    // Display
    op(1'b1, 16'hFE06, 16'h0048, 1'b0, "ddr_wr_48");
    op(1'b0, 16'hFE04, 16'h0, 1'b0, "dsr_busy");
    op(1'b1, 16'hFE06, 16'h0049, 1'b0, "ddr_wr_drop");
    op(1'b0, 16'hFE06, 16'h0, 1'b0, "ddr_rd_zero");
    dd_release();
    op(1'b0, 16'hFE04, 16'h0, 1'b0, "dsr_ready");

    // MCR write then reset
    op(1'b1, 16'hFFFE, 16'h0000, 1'b0, "mcr_wr_0");
    op(1'b0, 16'hFFFE, 16'h0, 1'b0, "mcr_rd_0");
    op(1'b1, 16'hFE00, 16'hFFFF, 1'b0, "kbsr_wr_ign");
    op(1'b1, 16'hFE06, 16'h0055, 1'b0, "ddr_wr_55");
    apply_reset();
    chk("rst2_mcr_run", mcr_run, 1'b1);
    chk("rst2_dd_valid", dd_valid, 1'b0);
    chk("rst2_dd_data", dd_data, 8'h00);
    op(1'b0, 16'hFFFE, 16'h0, 1'b0, "mcr_rd_8000");

    // Reset while waiting for RAM aborts the transaction
    @(negedge clk);
    mem_en = 1'b1; mem_we = 1'b0; mem_addr = 16'h3000;
    @(negedge clk);
    chk("abort_ram_en", ram_en, 1'b1);
    reset = 1'b1;
    mem_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    rdy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_ready) rdy_seen++;
    end
    chk("abort_no_ready", rdy_seen, 0);
    op(1'b0, 16'h3000, 16'h0, 1'b0, "after_abort_rd");
    op(1'b0, 16'hFE10, 16'h0, 1'b0, "unmapped_fe10");

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1: begin
          a = 16'($urandom_range(0, 16'hFDFF));
          op(1'b0, a, 16'h0, 1'($urandom_range(0, 1)), "rnd_ram_rd");
        end
        2, 3: begin
          a = 16'($urandom_range(0, 16'hFDFF));
          d = 16'($urandom);
          op(1'b1, a, d, 1'b0, "rnd_ram_wr");
        end
        4: begin
          a = dev_list[$urandom_range(0, 6)];
          op(1'b0, a, 16'h0, 1'b0, "rnd_dev_rd");
        end
        5: begin
          a = dev_list[$urandom_range(0, 6)];
          d = 16'($urandom);
          op(1'b1, a, d, 1'b0, "rnd_dev_wr");
        end
        6: begin
          if (!ref_full) kb_send(8'($urandom));
        end
        default: begin
          if (ref_ddv) dd_release();
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
